pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central hazard and control-flow sequencer for the 5-stage MIPS pipeline (F/D/E/M/W).
- Combines bus-wait, load-use, mult/div-busy and decode-resolved branch/jump events.
- Drives per-stage stall and flush (bubble) controls.
- Owns the delayed-branch redirect FSM: holds the decode-stage target until the delay slot has been fetched, then redirects fetch.

Parameters:
- ADDR_W, 32, PC / target width
- PERF_W, 32, width of optional performance counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_busy  in  1  fetch stage waiting on instruction bus
- d_busy  in  1  memory stage waiting on data bus
- load_use  in  1  decode load-use hazard (operand produced by a load in E)
- muldiv_busy  in  1  execute stage multi-cycle mult/div in progress
- br_taken  in  1  decode resolved a taken branch/jump this cycle
- br_target  in  ADDR_W  target PC accompanying br_taken
- redirect_ready  in  1  fetch accepts a redirect this cycle
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold that stage's pipeline register
- flush_d, flush_e, flush_m, flush_w  out  1 each  load a bubble into that stage's register
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  ADDR_W  redirect target (registered)
- fetch_kill  out  1  discard the instruction currently in fetch
- perf_stall_cycles  out  PERF_W  cycles with stall_f=1 (optional feature)
- perf_redirects  out  PERF_W  completed redirects (optional feature)

Behaviour:
- Stall/flush outputs are combinational from inputs and FSM state. Priority, highest first:
  - d_busy: stall_f/d/e/m=1, flush_w=1.
  - muldiv_busy: stall_f/d/e=1, flush_m=1.
  - load_use: stall_f/d=1, flush_e=1.
  - i_busy alone: stall_f=1, flush_d=1.
- A lower-priority condition never asserts a flush on a stage that a higher-priority condition stalls.
- FSM state != IDLE forces stall_f=1 unless redirect fires this cycle.
- Branch accept: br_taken && !stall_d. br_taken is ignored while stall_d=1; decode re-presents it.
- FSM states: IDLE, WAIT_SLOT, REDIR.
  - IDLE: on accept, latch redirect_pc<=br_target. Go to REDIR if !i_busy (delay slot captured this cycle), else WAIT_SLOT.
  - WAIT_SLOT: when i_busy falls, go to REDIR.
  - REDIR: redirect_valid=1. When redirect_ready=1 (and no d_busy): fetch_kill=1, then IDLE. Otherwise hold REDIR, redirect_pc stable.
- A branch accepted in the same cycle a redirect completes is legal: latch the new target and re-enter REDIR/WAIT_SLOT.
- br_taken while state != IDLE is a branch in a delay slot. It is ignored and does not overwrite redirect_pc.
- Reset values:
  - state=IDLE, redirect_pc=0, redirect_valid=0, fetch_kill=0.
  - All stall/flush outputs 0 while reset=1.
  - Perf counters 0.
- Reset mid-redirect drops the pending target; no redirect is issued afterwards.
- Latency: stalls take effect in the same cycle. Redirect appears at least 1 cycle after accept.

Optional Feature:
- PIPE_CTRL_PERF_EN defined:
  - perf_stall_cycles increments each cycle stall_f=1.
  - perf_redirects increments on each completed redirect.
  - Both wrap at 2^PERF_W.
- Undefined: both counters are constant 0 and no counter flops are instantiated.

Decomposition:
- Shared package pipeline_pkg holds:
  - ctrl_state_t enum (IDLE/WAIT_SLOT/REDIR).
  - stage_ctrl_t struct {stall, flush} per stage.
- One sub-module, redirect_fsm, holds the FSM, target register and fetch_kill.
- pipeline_ctrl holds the priority logic and perf counters.

Test Plan:
- load_use=1 for 1 cycle, all else 0 -> stall_f=stall_d=1, flush_e=1, other outputs 0; next cycle all 0.
- d_busy=1 and load_use=1 together for 3 cycles -> stall_f/d/e/m=1, flush_w=1, flush_e=0 each cycle.
- br_taken=1, br_target=32'hbfc0_0100, i_busy=0 -> next cycle redirect_valid=1, redirect_pc=32'hbfc0_0100; redirect_ready=1 gives fetch_kill=1 and IDLE the cycle after.
- br_taken with i_busy=1 for 4 more cycles -> WAIT_SLOT, redirect_valid=0 for those cycles, then REDIR with the original target.
- reset=1 in REDIR with redirect_ready=0 -> all outputs 0 next cycle; redirect_valid stays 0 after reset released.
- With PIPE_CTRL_PERF_EN: 5 stall_f cycles and 2 redirects -> perf_stall_cycles=5, perf_redirects=2. Without the macro: both read 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared types for the pipeline hazard/redirect controller:
//               redirect FSM state encoding and per-stage stall/flush bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SLOT = 2'd1,
        REDIR     = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_redirect_fsm.sv
`default_nettype none
// ============================================================================
// Module      : redirect_fsm
// Description : Delayed-branch redirect sequencer. Holds the decode-resolved
//               target until the delay slot is fetched, then redirects fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module redirect_fsm
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              i_busy,
    input  logic              d_busy,
    input  logic              stall_d,
    input  logic              redirect_ready,
    output logic              active,
    output logic              fire,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_kill
);

    ctrl_state_t       r_state;
    logic              r_redirect_valid;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic              r_fetch_kill;

    logic              w_accept;
    ctrl_state_t       w_after_accept;

    assign active = (r_state != IDLE);
    assign fire   = (r_state == REDIR) && redirect_ready && !d_busy;

    // A new branch may start only from IDLE or on the cycle the pending
    // redirect completes; anything else in flight is a delay-slot branch.
    assign w_accept       = br_taken && !stall_d && ((r_state == IDLE) || fire);
    assign w_after_accept = i_busy ? WAIT_SLOT : REDIR;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_fetch_kill     <= 1'b0;
        end else begin
            r_fetch_kill <= fire;
            if (w_accept) begin
                r_redirect_pc    <= br_target;
                r_state          <= w_after_accept;
                r_redirect_valid <= !i_busy;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_redirect_valid <= 1'b0;
                    end
                    WAIT_SLOT: begin
                        if (!i_busy) begin
                            r_state          <= REDIR;
                            r_redirect_valid <= 1'b1;
                        end
                    end
                    REDIR: begin
                        if (fire) begin
                            r_state          <= IDLE;
                            r_redirect_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state          <= IDLE;
                        r_redirect_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign fetch_kill     = r_fetch_kill;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : 5-stage pipeline hazard priority logic and redirect control.
//               Optional perf counters enabled by macro PIPE_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_busy,
    input  logic              d_busy,
    input  logic              load_use,
    input  logic              muldiv_busy,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              redirect_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_kill,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_redirects
);

    logic        w_stall_f;
    logic        w_flush_w;
    stage_ctrl_t w_ctrl_d;
    stage_ctrl_t w_ctrl_e;
    stage_ctrl_t w_ctrl_m;
    logic        w_fsm_active;
    logic        w_fire;

    // Each hazard stalls everything upstream of its stage and bubbles the
    // stage just below it; the if/else chain keeps lower-priority flushes off
    // stages that a higher-priority hazard is holding.
    always_comb begin
        w_stall_f = 1'b0;
        w_flush_w = 1'b0;
        w_ctrl_d  = '0;
        w_ctrl_e  = '0;
        w_ctrl_m  = '0;
        if (!reset) begin
            if (d_busy) begin
                w_stall_f      = 1'b1;
                w_ctrl_d.stall = 1'b1;
                w_ctrl_e.stall = 1'b1;
                w_ctrl_m.stall = 1'b1;
                w_flush_w      = 1'b1;
            end else if (muldiv_busy) begin
                w_stall_f      = 1'b1;
                w_ctrl_d.stall = 1'b1;
                w_ctrl_e.stall = 1'b1;
                w_ctrl_m.flush = 1'b1;
            end else if (load_use) begin
                w_stall_f      = 1'b1;
                w_ctrl_d.stall = 1'b1;
                w_ctrl_e.flush = 1'b1;
            end else if (i_busy) begin
                w_stall_f      = 1'b1;
                w_ctrl_d.flush = 1'b1;
            end
            if (w_fsm_active && !w_fire) begin
                w_stall_f = 1'b1;
            end
        end
    end

    assign stall_f = w_stall_f;
    assign stall_d = w_ctrl_d.stall;
    assign stall_e = w_ctrl_e.stall;
    assign stall_m = w_ctrl_m.stall;
    assign flush_d = w_ctrl_d.flush;
    assign flush_e = w_ctrl_e.flush;
    assign flush_m = w_ctrl_m.flush;
    assign flush_w = w_flush_w;

    redirect_fsm #(
        .ADDR_W (ADDR_W)
    ) u_redirect_fsm (
        .clk            (clk),
        .reset          (reset),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .i_busy         (i_busy),
        .d_busy         (d_busy),
        .stall_d        (w_ctrl_d.stall),
        .redirect_ready (redirect_ready),
        .active         (w_fsm_active),
        .fire           (w_fire),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_kill     (fetch_kill)
    );

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [PERF_W-1:0] C_PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] r_perf_stall_cycles;
    logic [PERF_W-1:0] r_perf_redirects;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall_cycles <= '0;
            r_perf_redirects    <= '0;
        end else begin
            if (w_stall_f) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + C_PERF_ONE;
            end
            if (w_fire) begin
                r_perf_redirects <= r_perf_redirects + C_PERF_ONE;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall_cycles;
    assign perf_redirects    = r_perf_redirects;
`else
    assign perf_stall_cycles = '0;
    assign perf_redirects    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl (vector table, directed
//               corner sequences, randomized run against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, i_busy, d_busy, load_use, muldiv_busy, br_taken, redirect_ready;
    logic [31:0] br_target;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_m, flush_w;
    logic        redirect_valid, fetch_kill;
    logic [31:0] redirect_pc, perf_stall_cycles, perf_redirects;

    always #5 clk = ~clk;

    pipeline_ctrl #(.ADDR_W(32), .PERF_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_busy            (i_busy),
        .d_busy            (d_busy),
        .load_use          (load_use),
        .muldiv_busy       (muldiv_busy),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .redirect_ready    (redirect_ready),
        .stall_f           (stall_f),
        .stall_d           (stall_d),
        .stall_e           (stall_e),
        .stall_m           (stall_m),
        .flush_d           (flush_d),
        .flush_e           (flush_e),
        .flush_m           (flush_m),
        .flush_w           (flush_w),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .fetch_kill        (fetch_kill),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_redirects    (perf_redirects)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a pending target plus whether its delay slot is in.
    logic        m_pend, m_slot, m_kill;
    logic [31:0] m_pc, m_ps, m_pr;
    logic [3:0]  x_stall;   // {m,e,d,f}
    logic [3:0]  x_flush;   // {w,m,e,d}
    logic        x_fire;

    typedef struct {
        logic       ib, db, lu, md;
        logic [3:0] stall;
        logic [3:0] flush;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pend = 1'b0; m_slot = 1'b0; m_kill = 1'b0;
        m_pc = '0; m_ps = '0; m_pr = '0;
    endtask

    task automatic apply(input logic rs, ib, db, lu, md, bt, input logic [31:0] tg, input logic rr);
        int depth;
        @(negedge clk);
        reset = rs; i_busy = ib; d_busy = db; load_use = lu; muldiv_busy = md;
        br_taken = bt; br_target = tg; redirect_ready = rr;
        #1;
        depth = db ? 4 : (md ? 3 : (lu ? 2 : (ib ? 1 : 0)));
        for (int s = 0; s < 4; s++) begin
            x_stall[s] = (s < depth);
            x_flush[s] = (depth == s + 1);
        end
        x_fire = m_pend && m_slot && rr && !db;
        if (m_pend && !x_fire) x_stall[0] = 1'b1;
        if (rs) begin
            x_stall = '0;
            x_flush = '0;
        end
        chk("stall", {stall_m, stall_e, stall_d, stall_f}, x_stall);
        chk("flush", {flush_w, flush_m, flush_e, flush_d}, x_flush);
        chk("redirect_valid", redirect_valid, m_pend && m_slot);
        chk("redirect_pc", redirect_pc, m_pc);
        chk("fetch_kill", fetch_kill, m_kill);
        chk("perf_stall_cycles", perf_stall_cycles, PERF_ON ? m_ps : 32'd0);
        chk("perf_redirects", perf_redirects, PERF_ON ? m_pr : 32'd0);
    endtask

    task automatic tick();
        logic acc;
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            acc = br_taken && !x_stall[1] && (!m_pend || x_fire);
            if (x_stall[0]) m_ps = m_ps + 32'd1;
            if (x_fire) m_pr = m_pr + 32'd1;
            m_kill = x_fire;
            if (acc) begin
                m_pend = 1'b1;
                m_slot = !i_busy;
                m_pc   = br_target;
            end else if (x_fire) begin
                m_pend = 1'b0;
            end else if (m_pend && !m_slot && !i_busy) begin
                m_slot = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic rs, ib, db, lu, md, bt, input logic [31:0] tg, input logic rr);
        apply(rs, ib, db, lu, md, bt, tg, rr);
        tick();
    endtask

    initial begin
        reset = 1'b1; i_busy = 1'b0; d_busy = 1'b0; load_use = 1'b0;
        muldiv_busy = 1'b0; br_taken = 1'b0; br_target = '0; redirect_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();

        // Reset state: every hazard asserted, all outputs still quiet.
        apply(1, 1, 1, 1, 1, 1, 32'h1234_5678, 1);
        chk("reset_stall_f", stall_f, 1'b0);
        tick();

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b0010};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0111, 4'b0100};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 4'b1000};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b0010};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'b0111, 4'b0100};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 4'b1000};
        for (int i = 0; i < 8; i++) begin
            apply(0, tbl[i].ib, tbl[i].db, tbl[i].lu, tbl[i].md, 0, 32'h0, 0);
            chk("tbl_stall", {stall_m, stall_e, stall_d, stall_f}, tbl[i].stall);
            chk("tbl_flush", {flush_w, flush_m, flush_e, flush_d}, tbl[i].flush);
            tick();
        end

        // Single-cycle load-use, then quiet.
        apply(0, 0, 0, 1, 0, 0, 32'h0, 0);
        chk("lu_stall", {stall_m, stall_e, stall_d, stall_f}, 4'b0011);
        chk("lu_flush", {flush_w, flush_m, flush_e, flush_d}, 4'b0010);
        tick();
        apply(0, 0, 0, 0, 0, 0, 32'h0, 0);
        chk("lu_after", {stall_m, stall_e, stall_d, stall_f, flush_w, flush_m, flush_e, flush_d}, 8'h00);
        tick();

        // d_busy masks load_use's flush for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 1, 0, 0, 32'h0, 0);
            chk("db_lu_stall", {stall_m, stall_e, stall_d, stall_f}, 4'b1111);
            chk("db_lu_flush_w", flush_w, 1'b1);
            chk("db_lu_flush_e", flush_e, 1'b0);
            tick();
        end

        // Branch with delay slot already fetched.
        apply(0, 0, 0, 0, 0, 1, 32'hbfc0_0100, 0);
        chk("br_rv_same_cycle", redirect_valid, 1'b0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 32'h0, 1);
        chk("br_rv", redirect_valid, 1'b1);
        chk("br_pc", redirect_pc, 32'hbfc0_0100);
        chk("br_fire_no_stall", stall_f, 1'b0);
        tick();
        apply(0, 0, 0, 0, 0, 0, 32'h0, 0);
        chk("br_kill", fetch_kill, 1'b1);
        chk("br_idle_rv", redirect_valid, 1'b0);
        tick();

        // Branch while fetch is busy: wait for the slot; delay-slot branch ignored.
        cyc(0, 1, 0, 0, 0, 1, 32'h8000_0040, 0);
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 0, 0, 0, 1, 32'hdead_beec, 1);
            chk("ws_rv", redirect_valid, 1'b0);
            chk("ws_stall_f", stall_f, 1'b1);
            tick();
        end
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 0);
        apply(0, 0, 0, 0, 0, 0, 32'h0, 0);
        chk("ws_rv_redir", redirect_valid, 1'b1);
        chk("ws_pc", redirect_pc, 32'h8000_0040);
        tick();
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 1);
        apply(0, 0, 0, 0, 0, 0, 32'h0, 0);
        chk("ws_kill", fetch_kill, 1'b1);
        tick();

        // Reset while a redirect is pending drops it.
        cyc(0, 0, 0, 0, 0, 1, 32'h0bad_f00d, 0);
        cyc(1, 0, 0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 0, 32'h0, 1);
            chk("rst_rv", redirect_valid, 1'b0);
            chk("rst_kill", fetch_kill, 1'b0);
            chk("rst_pc", redirect_pc, 32'h0);
            tick();
        end

        // Perf counters: 5 stall_f cycles and 2 redirects after reset.
        cyc(1, 0, 0, 0, 0, 0, 32'h0, 0);
        repeat (5) cyc(0, 1, 0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 32'h0000_1000 + i, 0);
            cyc(0, 0, 0, 0, 0, 0, 32'h0, 1);
        end
        apply(0, 0, 0, 0, 0, 0, 32'h0, 0);
        chk("perf_stall_5", perf_stall_cycles, PERF_ON ? 32'd5 : 32'd0);
        chk("perf_redir_2", perf_redirects, PERF_ON ? 32'd2 : 32'd0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 2) == 0),
                $urandom,
                ($urandom_range(0, 1) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
